// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for mux_n_to_1: steps sel through channels 0..N-1, samples mux_out
// after SETTLE dwell cycles and hands the assembled word out on valid/ready.
// Define MUX_SCAN_CONT_EN for continuous mode (DONE+ready restarts a scan directly).
module mux_scan_ctrl #(
  parameter int N      = 8,
  parameter int SETTLE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mux_out,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy,
  output logic [N-1:0]         word,
  output logic                 valid,
  input  logic                 ready
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [3:0]    dwell_r, dwell_nxt_s;
  logic [N-1:0]  cap_r, cap_nxt_s, cap_set_s;
  logic [SW-1:0] sel_nxt_s;
  logic [N-1:0]  word_nxt_s;
  logic          busy_nxt_s, valid_nxt_s;
  logic          sample_s, last_s;

  assign sample_s = (state_r == ST_SCAN) && (dwell_r == SETTLE_C);
  assign last_s   = (sel == LAST_IDX);

  // Capture register with the current channel's bit already merged in.
  always_comb begin
    cap_set_s      = cap_r;
    cap_set_s[sel] = mux_out;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_SCAN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (sample_s && last_s) state_nxt_s = ST_DONE;
        else                    state_nxt_s = ST_SCAN;
      end
      ST_DONE: begin
`ifdef MUX_SCAN_CONT_EN
        if (ready) state_nxt_s = ST_SCAN;
        else       state_nxt_s = ST_DONE;
`else
        if (ready) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_DONE;
`endif
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered below.
  always_comb begin
    sel_nxt_s   = sel;
    dwell_nxt_s = dwell_r;
    cap_nxt_s   = cap_r;
    word_nxt_s  = word;
    case (state_r)
      ST_SCAN: begin
        if (sample_s) begin
          dwell_nxt_s = 4'd0;
          cap_nxt_s   = cap_set_s;
          if (last_s) begin
            word_nxt_s = cap_set_s;
            sel_nxt_s  = '0;
          end else begin
            sel_nxt_s = sel + SW'(1);
          end
        end else begin
          dwell_nxt_s = dwell_r + 4'd1;
        end
      end
      ST_IDLE, ST_DONE: begin
        // Leaving either state always starts a scan from channel 0 with a clean capture.
        sel_nxt_s   = '0;
        dwell_nxt_s = 4'd0;
        cap_nxt_s   = '0;
      end
      default: begin
        sel_nxt_s   = '0;
        dwell_nxt_s = 4'd0;
        cap_nxt_s   = '0;
      end
    endcase
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    valid_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= '0;
      dwell_r <= 4'd0;
      cap_r   <= '0;
      word    <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      sel     <= sel_nxt_s;
      dwell_r <= dwell_nxt_s;
      cap_r   <= cap_nxt_s;
      word    <= word_nxt_s;
      busy    <= busy_nxt_s;
      valid   <= valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench: three scanners (N=8/S=0, N=4/S=2, N=2/S=0) each
// reading a modelled mux; expectations come from the scan timing arithmetic.
module tb_mux_scan_ctrl;

  localparam int NN [3] = '{8, 4, 2};
  localparam int SS [3] = '{0, 2, 0};

  logic       clk, rst_n, start, ready;
  logic [7:0] dat      [3];
  logic [7:0] exp_word [3];
  logic [2:0] sel8;
  logic [1:0] sel4;
  logic [0:0] sel2;
  logic [7:0] word8;
  logic [3:0] word4;
  logic [1:0] word2;
  logic       mo0, mo1, mo2;
  logic       busy0, busy1, busy2, valid0, valid1, valid2;
  logic [7:0] sel_v  [3];
  logic [7:0] word_v [3];
  logic       busy_v [3];
  logic       valid_v[3];

  int tests_run    = 0;
  int tests_failed = 0;

  assign mo0 = dat[0][sel8];
  assign mo1 = dat[1][sel4];
  assign mo2 = dat[2][sel2];

  always_comb begin
    sel_v[0]   = {5'd0, sel8};
    sel_v[1]   = {6'd0, sel4};
    sel_v[2]   = {7'd0, sel2};
    word_v[0]  = word8;
    word_v[1]  = {4'd0, word4};
    word_v[2]  = {6'd0, word2};
    busy_v[0]  = busy0;
    busy_v[1]  = busy1;
    busy_v[2]  = busy2;
    valid_v[0] = valid0;
    valid_v[1] = valid1;
    valid_v[2] = valid2;
  end

  mux_scan_ctrl #(.N(8), .SETTLE(0)) u_n8 (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_out(mo0), .sel(sel8),
    .busy(busy0), .word(word8), .valid(valid0), .ready(ready));
  mux_scan_ctrl #(.N(4), .SETTLE(2)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_out(mo1), .sel(sel4),
    .busy(busy1), .word(word4), .valid(valid1), .ready(ready));
  mux_scan_ctrl #(.N(2), .SETTLE(0)) u_n2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mux_out(mo2), .sel(sel2),
    .busy(busy2), .word(word2), .valid(valid2), .ready(ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] rand_data(input int i);
    return 8'($urandom) & 8'((1 << NN[i]) - 1);
  endfunction

  // t = edges since the start edge; bp = ready held low.
  task automatic check_cycle(input int t, input bit bp);
    for (int i = 0; i < 3; i++) begin
      int len, u;
      len = NN[i] * (SS[i] + 1);
      u   = t;
`ifdef MUX_SCAN_CONT_EN
      if (!bp) u = t % (len + 1);
`endif
      if (u < len) begin
        check_val($sformatf("sel%0d_t%0d", i, t), sel_v[i], 32'(u / (SS[i] + 1)));
        check_val($sformatf("busy%0d_t%0d", i, t), 32'(busy_v[i]), 32'd1);
        check_val($sformatf("valid%0d_t%0d", i, t), 32'(valid_v[i]), 32'd0);
      end else if (u == len || bp) begin
        check_val($sformatf("valid%0d_t%0d", i, t), 32'(valid_v[i]), 32'd1);
        check_val($sformatf("busy%0d_t%0d", i, t), 32'(busy_v[i]), 32'd1);
        check_val($sformatf("sel%0d_t%0d", i, t), sel_v[i], 32'd0);
        check_val($sformatf("word%0d_t%0d", i, t), word_v[i], 32'(exp_word[i]));
        if (bp) begin
          dat[i] = rand_data(i);
        end else begin
`ifdef MUX_SCAN_CONT_EN
          dat[i]      = rand_data(i);
          exp_word[i] = dat[i];
`endif
        end
      end else begin
        check_val($sformatf("idle_busy%0d_t%0d", i, t), 32'(busy_v[i]), 32'd0);
        check_val($sformatf("idle_valid%0d_t%0d", i, t), 32'(valid_v[i]), 32'd0);
        check_val($sformatf("idle_sel%0d_t%0d", i, t), sel_v[i], 32'd0);
      end
    end
  endtask

  task automatic run_scan(input bit bp);
    int last_t;
    for (int i = 0; i < 3; i++) begin
      dat[i]      = rand_data(i);
      exp_word[i] = dat[i];
    end
    ready  = bp ? 1'b0 : 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    last_t = bp ? 32 : 40;
    for (int t = 0; t <= last_t; t++) begin
      check_cycle(t, bp);
      if (bp && t == 14) start = 1'b1;
      else               start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (bp) begin
      ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("rel_valid%0d", i), 32'(valid_v[i]), 32'd0);
        check_val($sformatf("rel_sel%0d", i), sel_v[i], 32'd0);
`ifdef MUX_SCAN_CONT_EN
        check_val($sformatf("rel_busy%0d", i), 32'(busy_v[i]), 32'd1);
`else
        check_val($sformatf("rel_busy%0d", i), 32'(busy_v[i]), 32'd0);
`endif
      end
    end
  endtask

  // Asynchronous reset between clock edges, then confirm nothing restarts without start.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s_sel%0d", tag, i), sel_v[i], 32'd0);
      check_val($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 32'd0);
      check_val($sformatf("%s_valid%0d", tag, i), 32'(valid_v[i]), 32'd0);
      check_val($sformatf("%s_word%0d", tag, i), word_v[i], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s_idle_busy%0d", tag, i), 32'(busy_v[i]), 32'd0);
      check_val($sformatf("%s_idle_valid%0d", tag, i), 32'(valid_v[i]), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dat[i]      = rand_data(i);
      exp_word[i] = 8'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("por_sel%0d", i), sel_v[i], 32'd0);
      check_val($sformatf("por_busy%0d", i), 32'(busy_v[i]), 32'd0);
      check_val($sformatf("por_valid%0d", i), 32'(valid_v[i]), 32'd0);
      check_val($sformatf("por_word%0d", i), word_v[i], 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      run_scan(r % 2 == 1);
      reset_pulse($sformatf("rst%0d", r));
    end

    // Abort mid-scan while the 8-channel scanner is on channel 3.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid_sel8", sel_v[0], 32'd3);
    reset_pulse("mid");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits around mux_n_to_1. It drives the mux select lines and consumes the mux's single-bit output.
- It walks sel through channels 0..N-1 and samples the mux output once per channel, after a programmable settle dwell.
- It assembles the samples into an N-bit word and presents that word on a valid/ready handshake to the next stage.
- Together the pair forms an N-to-1 time-multiplexed bit reader.

Parameters:
- N, 8, channel count; legal 2..8; must match the attached mux_n_to_1 N.
- SETTLE, 0, extra dwell cycles per channel before sampling; legal 0..15.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one scan; sampled only in IDLE.
- mux_out  input  1  connects to the mux out port.
- sel  output  $clog2(N)  registered select; connects to the mux sel port.
- busy  output  1  high in SCAN and DONE.
- word  output  N  assembled result; bit i = mux_out sampled while sel==i.
- valid  output  1  word available.
- ready  input  1  downstream accepts word.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low. Every flop clears immediately on rst_n low, independent of clk.
- Reset values: sel=0, busy=0, word=0, valid=0. Internal state=IDLE, dwell counter=0, capture register=0.
- State machine has three states: IDLE, SCAN, DONE.
- IDLE:
  - sel=0, busy=0, valid=0.
  - start=1 at an edge moves to SCAN with sel=0, dwell=0, capture=0.
- SCAN:
  - busy=1. sel holds the current index idx.
  - The dwell counter increments each cycle, 0..SETTLE.
  - At the edge where dwell==SETTLE, capture[idx] is loaded from mux_out and dwell returns to 0.
  - If idx<N-1 at that edge: sel becomes idx+1.
  - If idx==N-1 at that edge: word is loaded with the full capture (including the bit sampled at this edge), sel returns to 0, valid is set to 1, and the state moves to DONE.
- Timing: sel is registered and the mux is combinational, so a sample always sees mux_out for the current sel. With SETTLE=0 each channel occupies exactly 1 cycle.
- Latency: valid rises N*(SETTLE+1) cycles after the edge that accepted start. Example: N=8, SETTLE=0 gives 8 cycles.
- DONE:
  - valid=1, busy=1; word is frozen.
  - An edge with ready=1 clears valid and moves to IDLE.
  - ready=0 holds valid and word indefinitely.
- valid never drops without ready; word never changes while valid=1.
- start is ignored in SCAN and DONE; it is not queued.
- start held high continuously in IDLE begins a new scan on the edge after the DONE->IDLE transfer. This gives one idle cycle between scans.
- ready while valid=0 has no effect.
- mux_out is only sampled at the capture edge; it is don't-care otherwise.
- rst_n asserted mid-scan or in DONE aborts everything: outputs return to reset values and any partial capture is discarded.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined (continuous mode): a DONE edge with ready=1 goes straight to SCAN (sel=0, dwell=0, capture=0) instead of IDLE. There is no gap cycle, and start is needed only for the first scan after reset. Scan period with ready tied high is N*(SETTLE+1)+1 cycles.
- Undefined: one-shot behaviour exactly as described under Behaviour.

Test Plan:
- Reset and one-shot: N=8, SETTLE=0, mux data_in=8'hA5. Pulse start, hold ready=1 -> sel steps 0,1,...,7 on consecutive cycles. valid=1 with word=8'hA5 exactly 8 cycles after the start edge, for 1 cycle. Then busy=0.
- Settle dwell: N=4, SETTLE=2, data_in=4'b0110 -> each sel value held 3 cycles. valid after 12 cycles with word=4'b0110.
- Backpressure: ready=0 for 20 cycles after valid -> valid stays 1 and word is stable. A second start pulse during that time is ignored. ready=1 -> valid drops next edge and state is IDLE.
- Reset mid-operation: deassert rst_n asynchronously while sel==3 -> sel, busy, valid and word become 0 immediately, before the next clk edge. After release with no start, the block stays idle.
- Minimum N: N=2, data_in=2'b10 -> sel is 1 bit and toggles 0 then 1. word=2'b10 after 2 cycles.
- MUX_SCAN_CONT_EN defined, ready tied 1, single start: data_in changes from 8'h3C to 8'hC3 mid-run -> back-to-back valid pulses every 9 cycles. The first word is 8'h3C and the words after the change show 8'hC3. No second start is required.
